// File: rtl/sc_lfsr_checker.sv
// sc_lfsr_checker: synchronises to an 8-bit LFSR word stream, tracks lock and counts mispredicted words
module sc_lfsr_checker #(
  parameter int SYNC_COUNT   = 4,
  parameter int LOSS_COUNT   = 3,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                    SC_LFSRCHK_CLOCK_50,
  input  logic                    SC_LFSRCHK_RESET_InHigh,
  input  logic [7:0]              SC_LFSRCHK_data_InBUS,
  input  logic                    SC_LFSRCHK_valid_In,
  input  logic                    SC_LFSRCHK_clear_In,
  output logic                    SC_LFSRCHK_locked_Out,
  output logic                    SC_LFSRCHK_error_Out,
  output logic [ERRCNT_WIDTH-1:0] SC_LFSRCHK_errcount_OutBUS,
  output logic [7:0]              SC_LFSRCHK_expected_OutBUS
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);
  state_t                  state_q;
  logic [3:0]              match_q;
  logic [3:0]              miss_q;
  logic [7:0]              expected_q;
  logic                    locked_q;
  logic                    error_q;
  logic [ERRCNT_WIDTH-1:0] errcount_q;
  logic [ERRCNT_WIDTH-1:0] errcount_d;
  logic [7:0]              next_data;
  logic [7:0]              next_exp;
  logic                    hit;
  logic                    zero;
  // successor words, match detect and saturating error increment
  always_comb begin
    next_data  = {SC_LFSRCHK_data_InBUS[6:0], SC_LFSRCHK_data_InBUS[1] ^ SC_LFSRCHK_data_InBUS[3] ^ SC_LFSRCHK_data_InBUS[5] ^ SC_LFSRCHK_data_InBUS[7]};
    next_exp   = {expected_q[6:0], expected_q[1] ^ expected_q[3] ^ expected_q[5] ^ expected_q[7]};
    hit        = SC_LFSRCHK_data_InBUS == expected_q;
    zero       = SC_LFSRCHK_data_InBUS == 8'h00;
    errcount_d = &errcount_q ? errcount_q : errcount_q + ERRCNT_WIDTH'(1);
  end
  // hunt/verify/locked state machine with registered outputs; clear beats a coincident error count
  always_ff @(posedge SC_LFSRCHK_CLOCK_50 or posedge SC_LFSRCHK_RESET_InHigh) begin
    if (SC_LFSRCHK_RESET_InHigh) begin
      state_q    <= HUNT;
      match_q    <= '0;
      miss_q     <= '0;
      expected_q <= '0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      errcount_q <= '0;
    end else begin
      error_q <= 1'b0;
      if (SC_LFSRCHK_clear_In) errcount_q <= '0;
      if (SC_LFSRCHK_valid_In) begin
        case (state_q)
          HUNT: begin
            if (!zero) begin
              expected_q <= next_data;
              match_q    <= '0;
              state_q    <= VERIFY;
            end
          end
          VERIFY: begin
            if (hit) begin
              expected_q <= next_data;
              if (match_q == SYNC_LAST) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= '0;
                match_q  <= '0;
              end else begin
                match_q <= match_q + 4'd1;
              end
            end else if (!zero) begin
              expected_q <= next_data;
              match_q    <= '0;
            end else begin
              state_q    <= HUNT;
              expected_q <= '0;
            end
          end
          LOCKED: begin
            if (hit) begin
              miss_q     <= '0;
              expected_q <= next_exp;
            end else begin
              error_q <= 1'b1;
              if (!SC_LFSRCHK_clear_In) errcount_q <= errcount_d;
              if (miss_q == LOSS_LAST) begin
                state_q    <= HUNT;
                locked_q   <= 1'b0;
                expected_q <= '0;
                miss_q     <= '0;
              end else begin
                miss_q     <= miss_q + 4'd1;
                expected_q <= next_exp;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end
  assign SC_LFSRCHK_locked_Out      = locked_q;
  assign SC_LFSRCHK_error_Out       = error_q;
  assign SC_LFSRCHK_errcount_OutBUS = errcount_q;
  assign SC_LFSRCHK_expected_OutBUS = expected_q;
endmodule

// File: tb/tb_sc_lfsr_checker.sv
// tb_sc_lfsr_checker: scoreboard bench driving a default checker and a narrow-counter checker from one stimulus stream
module tb_sc_lfsr_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v = 1'b0;
  logic       c = 1'b0;
  logic [7:0] d = 8'h00;
  logic        la, ea, lb, eb;
  logic [15:0] ca;
  logic [1:0]  cb;
  logic [7:0]  xa, xb;
  typedef struct packed {
    logic [1:0]  mode;
    logic [3:0]  run;
    logic [3:0]  miss;
    logic [7:0]  exp;
    logic        lck;
    logic        err;
    logic [15:0] cnt;
  } m_t;
  int   checks = 0;
  int   failures = 0;
  m_t   qa[$];
  m_t   qb[$];
  m_t   ma = '0;
  m_t   mb = '0;
  logic [7:0] acq [5] = '{8'h81, 8'h03, 8'h07, 8'h0F, 8'h1E};
  logic [7:0] hunt[6] = '{8'h00, 8'h00, 8'h81, 8'h03, 8'h55, 8'h07};
  always #5 clk = ~clk;
  sc_lfsr_checker dut_a (
    .SC_LFSRCHK_CLOCK_50(clk), .SC_LFSRCHK_RESET_InHigh(rst),
    .SC_LFSRCHK_data_InBUS(d), .SC_LFSRCHK_valid_In(v), .SC_LFSRCHK_clear_In(c),
    .SC_LFSRCHK_locked_Out(la), .SC_LFSRCHK_error_Out(ea),
    .SC_LFSRCHK_errcount_OutBUS(ca), .SC_LFSRCHK_expected_OutBUS(xa)
  );
  sc_lfsr_checker #(.SYNC_COUNT(4), .LOSS_COUNT(8), .ERRCNT_WIDTH(2)) dut_b (
    .SC_LFSRCHK_CLOCK_50(clk), .SC_LFSRCHK_RESET_InHigh(rst),
    .SC_LFSRCHK_data_InBUS(d), .SC_LFSRCHK_valid_In(v), .SC_LFSRCHK_clear_In(c),
    .SC_LFSRCHK_locked_Out(lb), .SC_LFSRCHK_error_Out(eb),
    .SC_LFSRCHK_errcount_OutBUS(cb), .SC_LFSRCHK_expected_OutBUS(xb)
  );
  function automatic logic [7:0] n8(input logic [7:0] w);
    return ((w << 1) & 8'hFE) | 8'($countones(w & 8'hAA) & 1);
  endfunction
  function automatic m_t model(input m_t m, input logic vv, input logic [7:0] dd, input logic cc, input int loss, input int width);
    m_t r;
    int maxc;
    r = m;
    maxc = (1 << width) - 1;
    r.err = 1'b0;
    if (vv) begin
      if (r.mode == 0) begin
        if (dd != 0) begin r.exp = n8(dd); r.run = 0; r.mode = 1; end
      end else if (r.mode == 1) begin
        if (dd == r.exp) begin
          r.exp = n8(dd);
          r.run = r.run + 1;
          if (r.run == 4) begin r.mode = 2; r.lck = 1; r.miss = 0; r.run = 0; end
        end else if (dd != 0) begin
          r.exp = n8(dd); r.run = 0;
        end else begin
          r.mode = 0; r.exp = 0;
        end
      end else begin
        if (dd == r.exp) begin
          r.miss = 0; r.exp = n8(r.exp);
        end else begin
          r.err = 1;
          if (int'(r.cnt) < maxc) r.cnt = r.cnt + 1;
          r.miss = r.miss + 1;
          if (int'(r.miss) == loss) begin r.mode = 0; r.lck = 0; r.exp = 0; r.miss = 0; end
          else r.exp = n8(r.exp);
        end
      end
    end
    if (cc) r.cnt = 0;
    return r;
  endfunction
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic step(input logic r, input logic vv, input logic [7:0] dd, input logic cc);
    @(negedge clk);
    rst = r; v = vv; d = dd; c = cc;
    if (r) begin ma = '0; mb = '0; end
    else begin ma = model(ma, vv, dd, cc, 3, 16); mb = model(mb, vv, dd, cc, 8, 2); end
    qa.push_back(ma);
    qb.push_back(mb);
  endtask
  task automatic feed(input logic [7:0] w);
    step(1'b0, 1'b1, w, 1'b0);
  endtask
  task automatic acquire();
    for (int i = 0; i < 5; i++) feed(acq[i]);
  endtask
  initial begin
    m_t a, b;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        a = qa.pop_front();
        b = qb.pop_front();
        chk("a_locked", int'(la), int'(a.lck));
        chk("a_error", int'(ea), int'(a.err));
        chk("a_errcount", int'(ca), int'(a.cnt));
        chk("a_expected", int'(xa), int'(a.exp));
        chk("b_locked", int'(lb), int'(b.lck));
        chk("b_error", int'(eb), int'(b.err));
        chk("b_errcount", int'(cb), int'(b.cnt));
        chk("b_expected", int'(xb), int'(b.exp));
      end
    end
  end
  initial begin
    logic [7:0] g;
    g = 8'h81;
    repeat (3) step(1'b1, 1'b1, 8'h81, 1'b0);
    acquire();
    feed(8'h3D);
    feed(8'h78);
    repeat (3) feed(8'hFF);
    acquire();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) feed(hunt[i]);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    acquire();
    repeat (5) feed(8'hFF);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    acquire();
    repeat (20) step(1'b0, 1'b0, 8'hFF, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_locked", int'(la), 0);
    chk("async_error", int'(ea), 0);
    chk("async_errcount", int'(ca), 0);
    chk("async_expected", int'(xa), 0);
    qa.delete();
    qb.delete();
    ma = '0;
    mb = '0;
    qa.push_back(ma);
    qb.push_back(mb);
    step(1'b1, 1'b1, 8'h81, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic vv, cc, rr;
      logic [7:0] dd;
      r  = $urandom_range(0, 99);
      vv = $urandom_range(0, 3) != 0;
      cc = $urandom_range(0, 29) == 0;
      rr = $urandom_range(0, 299) == 0;
      dd = 8'($urandom);
      if (vv) begin
        if (r < 80) begin dd = g; g = n8(g); end
        else if (r < 92) dd = (r < 88) ? 8'($urandom) : 8'h00;
        else begin g = 8'($urandom_range(1, 255)); dd = g; g = n8(g); end
      end
      step(rr, vv, dd, cc);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("drain", qa.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
